// File: rtl/dino_event_controller.sv
// Event sequencer for the dinosaur processor: frame tick generation, jump-button debounce
// and sticky collision latch, each cleared by the processor through toggle bits in r25.
module dino_event_controller #(
   parameter int unsigned FRAME_DIV       = 833333,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        button_raw,
   input  logic        collision_raw,
   input  logic [31:0] ack_word,
   output logic        button_signal,
   output logic        screen_signal,
   output logic        collision_signal,
   output logic [31:0] frame_count,
   output logic [15:0] overrun_count
);
   localparam int DIV_W = $clog2(FRAME_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic {F_IDLE, F_PEND} frame_state_t;
   typedef enum logic [1:0] {DB_ST0, DB_W1, DB_ST1, DB_W0} db_state_t;

   logic             btn_meta, btn_s;
   logic             col_meta, col_s;
   logic [1:0]       ack_q;
   logic             frame_ack, col_clr, run, tick;
   logic [DIV_W-1:0] div;
   frame_state_t     fr_state, fr_next;
   logic             fc_inc, ovr_inc;
   db_state_t        db_state, db_next;
   logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
   logic             unused_ack;

   assign unused_ack = ^ack_word[31:3];

   // Toggle-style acks: any change of an r25 bit is a one-cycle event.
   assign frame_ack = ack_word[0] ^ ack_q[0];
   assign col_clr   = ack_word[1] ^ ack_q[1];
   assign run       = ack_word[2];
   assign tick      = run && (div == DIV_LAST);

   assign screen_signal = (fr_state == F_PEND);
   assign button_signal = (db_state == DB_ST1) || (db_state == DB_W0);

   always_comb begin
      fr_next = fr_state;
      fc_inc  = 1'b0;
      ovr_inc = 1'b0;
      case (fr_state)
         F_IDLE: begin
            if (tick) begin
               fr_next = F_PEND;
               fc_inc  = 1'b1;
            end
         end
         F_PEND: begin
            // A tick with a simultaneous ack starts a fresh frame; not an overrun.
            if (tick) begin
               fc_inc  = 1'b1;
               ovr_inc = !frame_ack;
            end else if (frame_ack) begin
               fr_next = F_IDLE;
            end
         end
      endcase
   end

   // cnt is 0 in the stable states, so cnt+1 also gives the first wait count.
   always_comb begin
      db_next  = db_state;
      cnt_next = cnt;
      cnt_inc  = cnt + 1'b1;
      case (db_state)
         DB_ST0, DB_W1: begin
            if (!btn_s) begin
               db_next  = DB_ST0;
               cnt_next = '0;
            end else if (cnt_inc == DEB_N) begin
               db_next  = DB_ST1;
               cnt_next = '0;
            end else begin
               db_next  = DB_W1;
               cnt_next = cnt_inc;
            end
         end
         DB_ST1, DB_W0: begin
            if (btn_s) begin
               db_next  = DB_ST1;
               cnt_next = '0;
            end else if (cnt_inc == DEB_N) begin
               db_next  = DB_ST0;
               cnt_next = '0;
            end else begin
               db_next  = DB_W0;
               cnt_next = cnt_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         btn_meta         <= 1'b0;
         btn_s            <= 1'b0;
         col_meta         <= 1'b0;
         col_s            <= 1'b0;
         ack_q            <= 2'b00;
         div              <= '0;
         fr_state         <= F_IDLE;
         db_state         <= DB_ST0;
         cnt              <= '0;
         frame_count      <= 32'd0;
         overrun_count    <= 16'd0;
         collision_signal <= 1'b0;
      end else begin
         btn_meta <= button_raw;
         btn_s    <= btn_meta;
         col_meta <= collision_raw;
         col_s    <= col_meta;
         ack_q    <= ack_word[1:0];
         div      <= (!run || tick) ? '0 : div + 1'b1;
         fr_state <= fr_next;
         db_state <= db_next;
         cnt      <= cnt_next;
         if (fc_inc)
            frame_count <= frame_count + 32'd1;
         if (ovr_inc && (overrun_count != 16'hFFFF))
            overrun_count <= overrun_count + 16'd1;
         // Set has priority over a clear arriving in the same cycle.
         collision_signal <= col_s | (collision_signal & ~col_clr);
      end
   end
endmodule

// File: doc/dino_event_controller.md
# dino_event_controller

Sequences the asynchronous game events that feed the dinosaur processor's register-mapped inputs. It generates the frame tick, debounces the jump button and latches collisions. Each event is held as a flag that the processor clears through a toggle handshake on its r25 output word. The block sits between the board pins/sprite logic and the `button_signal`, `screen_signal` and `collision_signal` inputs of the processor wrapper. Its `frame_count` output drives the wrapper's r20 input.

## Interface
- `FRAME_DIV`, 833333: clock cycles per frame tick (60 Hz at 50 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before the button output changes; must be ≥ 1.
- `clock` in 1: single system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `button_raw` in 1: raw jump-button pin, asynchronous.
- `collision_raw` in 1: collision indication from sprite-overlap logic, asynchronous level or pulse of ≥ 1 cycle.
- `ack_word` in 32: processor register r25 output.
  - bit0: frame-ack toggle.
  - bit1: collision-clear toggle.
  - bit2: run enable (level).
  - All other bits are ignored.
- `button_signal` out 1: debounced button level.
- `screen_signal` out 1: frame pending, waiting for processor ack.
- `collision_signal` out 1: sticky collision flag.
- `frame_count` out 32: number of frame ticks since reset.
- `overrun_count` out 16: frames that ticked while the previous frame was still pending.

## Operation
- **Synchronizers:** `button_raw` and `collision_raw` each pass through 2 flops (`btn_s`, `col_s`). `ack_word` is already synchronous and is not synchronized.
- **Ack edge detect:**
  - `ack_q[1:0]` registers `ack_word[1:0]` every cycle.
  - `frame_ack = ack_word[0] ^ ack_q[0]`.
  - `col_clr = ack_word[1] ^ ack_q[1]`.
  - Each ack is a single-cycle event per toggle.
- **Frame divider:**
  - `div` counts 0..FRAME_DIV-1 while `ack_word[2]=1`.
  - `tick` is asserted in the cycle `div==FRAME_DIV-1`; `div` then wraps to 0.
  - While `ack_word[2]=0`, `div` is held at 0 and no tick occurs.
- **Frame FSM, IDLE/PENDING; `screen_signal=1` exactly in PENDING:**
  - IDLE, `tick` → PENDING; `frame_count++` (wraps at 2^32).
  - IDLE, `frame_ack` → ignored.
  - PENDING, `frame_ack` and no `tick` → IDLE.
  - PENDING, `tick` and no `frame_ack` → stay PENDING; `frame_count++`; `overrun_count++`, saturating at 0xFFFF.
  - PENDING, `tick` and `frame_ack` in the same cycle → stay PENDING; `frame_count++`; no overrun.
- **Debounce FSM, states ST0/W1/ST1/W0; `button_signal=1` in ST1 and W0:**
  - ST0, `btn_s=1` → W1 with `cnt=1`.
  - W1, `btn_s=1` → `cnt++`. When `cnt==DEBOUNCE_CYCLES` → ST1.
  - W1, `btn_s=0` → ST0 with `cnt=0`.
  - ST1 and W0 mirror ST0 and W1 for a 0 level.
- **Collision:**
  - `collision_signal` sets on `col_s=1` and clears on `col_clr`.
  - If set and clear occur in the same cycle, set wins.
  - The flag is independent of run enable.

## Timing
- **Reset values:**
  - `button_signal`, `screen_signal`, `collision_signal` = 0.
  - `frame_count` = 0, `overrun_count` = 0.
  - `div`, `cnt`, `ack_q` = 0; FSMs in IDLE and ST0.
  - Reset asserted mid-frame or mid-debounce discards all progress.
  - With `ack_word` still holding nonzero toggle bits at reset release, the first post-reset compare produces one spurious ack. This is accepted: the processor also resets r25 to 0.
- **Frame latency:**
  - If `ack_word[2]` rises before edge E, the first tick is in cycle E+FRAME_DIV-1.
  - `screen_signal` and `frame_count` update at the following edge.
  - Ticks then repeat every FRAME_DIV cycles.
- **Ack latency:** if `ack_word[0]` toggles at edge A, `screen_signal` falls at edge A+1.
- **Button latency:** a raw level held stable from edge R changes `button_signal` at edge R+2+DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES sync cycles produce no output change.
- **Collision latency:** `collision_raw` high at edge C sets `collision_signal` at edge C+3.

## Test plan
Parameters for all scenarios: FRAME_DIV=10, DEBOUNCE_CYCLES=4.
- **Reset/idle:** hold reset 3 cycles with `ack_word=0`, run 50 cycles → all outputs 0 and `frame_count=0`.
- **Frame cadence and ack:** set `ack_word=4`, never ack → `screen_signal` rises on the 10th edge. Observe 3 more ticks → `frame_count=4`, `overrun_count=3`. Toggle bit0 (`ack_word=5`) → `screen_signal` falls next edge.
- **Simultaneous tick and ack:** toggle bit0 in the exact cycle `div==9` while PENDING → `screen_signal` stays 1, `frame_count` increments, `overrun_count` unchanged.
- **Debounce:** 3-cycle high glitch on `button_raw` → `button_signal` stays 0. Hold high → `button_signal` = 1 exactly 6 edges after the raw rise. Hold low again → falls 6 edges later.
- **Collision:** 1-cycle `collision_raw` pulse → `collision_signal` = 1 at +3 edges and holds. Toggle bit1 while `collision_raw` is high → stays 1. Toggle again after `collision_raw` is low → clears next edge.
- **Reset mid-operation:** assert reset during PENDING with `cnt=2` → all state cleared next edge. After release with `ack_word=4` → first tick arrives a full 10 cycles later.
